// File: rtl/exp_fxp_unpack.sv
// exp_fxp_unpack -- streaming fixed-point expander and lane unpacker.
//
// Takes a packed word of LANES narrow fixed-point values and emits them one
// per cycle, lane 0 first. Each value is widened exactly to the output format:
// the integer part is sign- or zero-extended and the fraction is zero-padded.
// Nothing is rounded or saturated.
//
// Optional feature macro: EXP_FXP_LAST_EN adds the out_last port, which flags
// the final lane of each word.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   in_valid/in_ready    packed input word handshake
//   in_data              LANES*I_PREC bits, lane k at [k*I_PREC +: I_PREC]
//   out_valid/out_ready  expanded output handshake
//   out_data             O_PREC-bit expanded value
//   out_lane             index of the lane being emitted
//   out_last             (EXP_FXP_LAST_EN only) final lane of the word

package exp_fxp_pkg;
  typedef struct packed {
    logic       sign;
    logic [7:0] prec;
    logic [7:0] frac;
  } dconf_t;

  // Narrow stored format: signed Q4.4. Wide arithmetic format: signed Q8.8.
  localparam dconf_t DEF_DCONFS_FXP = '{sign: 1'b1, prec: 8'd8,  frac: 8'd4};
  localparam dconf_t DEF_DCONF_FXP  = '{sign: 1'b1, prec: 8'd16, frac: 8'd8};
endpackage

module exp_fxp_unpack
  import exp_fxp_pkg::*;
#(
  parameter dconf_t I_CONF = DEF_DCONFS_FXP,
  parameter dconf_t O_CONF = DEF_DCONF_FXP,
  parameter int     LANES  = 4,
  parameter int     I_PREC = int'(I_CONF.prec),
  parameter int     O_PREC = int'(O_CONF.prec)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*I_PREC-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [O_PREC-1:0]        out_data,
  output logic [$clog2(LANES)-1:0] out_lane
`ifdef EXP_FXP_LAST_EN
  ,
  output logic                     out_last
`endif
);

  localparam int LW     = $clog2(LANES);
  localparam int I_FRAC = int'(I_CONF.frac);
  localparam int O_FRAC = int'(O_CONF.frac);
  localparam int I_INT  = I_PREC - I_FRAC;
  localparam int O_INT  = O_PREC - O_FRAC;
  localparam int FPAD   = O_FRAC - I_FRAC;
  localparam logic [LW-1:0] LAST = LW'(LANES - 1);

  // Reject configurations that cannot be widened exactly.
  if (LANES < 2) begin : g_bad_lanes
    $error("exp_fxp_unpack: LANES must be >= 2");
  end
  if (O_FRAC < I_FRAC) begin : g_bad_frac
    $error("exp_fxp_unpack: output fraction narrower than input fraction");
  end
  if (O_INT < I_INT) begin : g_bad_int
    $error("exp_fxp_unpack: output integer part narrower than input");
  end
  if (O_CONF.sign != I_CONF.sign) begin : g_bad_sign
    $error("exp_fxp_unpack: input and output signedness differ");
  end

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                         state_q, state_d;
  logic [LW-1:0]                  lane_q,  lane_d;
  logic [LANES-1:0][I_PREC-1:0]   word_q,  word_d;
  logic                           rdy, vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lane_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
    end
  end

  // Next state. The final-lane handshake doubles as the input acceptance
  // slot, so a waiting word is captured with no bubble between words.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    word_d  = word_q;
    rdy     = 1'b0;
    vld     = 1'b0;
    case (state_q)
      IDLE: begin
        rdy = 1'b1;
        if (in_valid) begin
          word_d  = in_data;
          lane_d  = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        vld = 1'b1;
        if (out_ready) begin
          if (lane_q != LAST) begin
            lane_d = lane_q + LW'(1);
          end else begin
            rdy    = 1'b1;
            lane_d = '0;
            if (in_valid) begin
              word_d = in_data;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Exact widening of the current lane: place v at the bottom, fill the
  // extra integer bits with sign (or zero), then shift up to pad the fraction.
  logic [I_PREC-1:0] v;
  logic [O_PREC-1:0] ext;

  always_comb begin
    v   = word_q[lane_q];
    ext = '0;
    if (I_CONF.sign) ext = {O_PREC{v[I_PREC-1]}};
    ext[I_PREC-1:0] = v;
  end

  // Outputs are forced quiet while reset is asserted so nothing leaks out
  // during the reset cycle itself.
  assign in_ready  = rdy & ~reset;
  assign out_valid = vld & ~reset;
  assign out_data  = reset ? '0 : (ext << FPAD);
  assign out_lane  = reset ? '0 : lane_q;

`ifdef EXP_FXP_LAST_EN
  assign out_last  = out_valid & (lane_q == LAST);
`endif

endmodule

// File: doc/exp_fxp_unpack.md
# exp_fxp_unpack

Streaming fixed-point expander and lane unpacker. Accepts packed words holding `LANES` narrow fixed-point values and emits them one per cycle, each widened exactly to the output format. The widening uses sign or zero extension of the integer part and zero padding of the fraction. It is the read-side counterpart of the precision-reduction stage: narrow stored or transferred operands re-enter wide arithmetic through this block.

## Interface
Parameters:
- `I_CONF`, default `DEF_DCONFS_FXP`: `dconf_t` of each narrow input lane (`sign`, `prec`, `frac`).
- `O_CONF`, default `DEF_DCONF_FXP`: `dconf_t` of the wide output.
- `LANES`, default 4: narrow values per input word; must be ≥ 2.
- `I_PREC`, default `I_CONF.prec`: narrow lane width.
- `O_PREC`, default `O_CONF.prec`: output width.
- Legality:
  - `O_CONF.frac ≥ I_CONF.frac`.
  - `(O_PREC−O_CONF.frac) ≥ (I_PREC−I_CONF.frac)`.
  - `O_CONF.sign == I_CONF.sign`.
  - Any violation is an elaboration error.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: packed word offered.
- `in_ready` out 1: block accepts word this cycle.
- `in_data` in `LANES*I_PREC`: lane k occupies bits `[k*I_PREC +: I_PREC]`.
- `out_valid` out 1: `out_data` valid.
- `out_ready` in 1: consumer accepts `out_data`.
- `out_data` out `O_PREC`: expanded value.
- `out_lane` out `$clog2(LANES)`: index of the lane being emitted.
- `out_last` out 1: present only with `EXP_FXP_LAST_EN`.

## Operation
- FSM has two states.
  - IDLE: `in_ready`=1, `out_valid`=0.
  - EMIT: `out_valid`=1.
- IDLE, `in_valid`=1: capture `in_data` into the word buffer, set lane=0, go to EMIT.
- EMIT, `out_ready`=1, lane<LANES−1: increment lane and stay in EMIT.
- EMIT, `out_ready`=1, lane==LANES−1:
  - `in_ready`=1 in this cycle only; it is combinational from `out_ready`.
  - If `in_valid`=1: capture the new word, set lane=0, stay in EMIT (back-to-back, no bubble).
  - Otherwise go to IDLE.
- EMIT, `out_ready`=0: hold state. `out_data`, `out_lane` and the buffer stay stable. `in_ready`=0.
- Lanes are emitted in order 0 … LANES−1.
- Expansion of lane value v is combinational from the buffer and lane counter. It is exact, with no rounding or saturation:
  - Fraction: append `O_FRAC−I_FRAC` zero bits.
  - Integer, signed: replicate `v[I_PREC−1]` into the `(O_INT−I_INT)` upper bits.
  - Integer, unsigned: zero-fill the upper bits.
- Outputs under reset: state=IDLE, lane=0, buffer=0, `out_valid`=0, `out_data`=0, `out_lane`=0, `in_ready`=0, `out_last`=0.
- Reset mid-word: the buffered word is discarded and no further lanes of it are emitted.
- `in_data` is ignored whenever `in_ready`=0.

## Timing
- Word accepted at edge N → lane 0 valid from cycle N+1.
- Throughput: one lane per cycle while `out_ready`=1, i.e. LANES cycles per word with no gap between words.
- Stalls on `out_ready` extend emission cycle-for-cycle.
- Combinational path `out_ready`→`in_ready` exists only in EMIT with lane==LANES−1.
- No combinational path from `in_*` to `out_*`.

## Configuration
- `EXP_FXP_LAST_EN` defined:
  - The `out_last` port exists.
  - `out_last`=1 exactly when `out_valid`=1 and lane==LANES−1, and 0 otherwise.
  - It marks word boundaries for downstream accumulators.
- Not defined: the `out_last` port and its logic are absent; all other behaviour is identical.

## Test plan
Default bench: I signed prec8/frac4, O signed prec16/frac8, LANES=4.

- Single word, `out_ready`=1:
  - Stimulus: `in_data`=0x7F_10_F8_80 (lane0=0x80).
  - Expected: 0xF800, 0xFF80, 0x0100, 0x07F0 on cycles N+1..N+4, `out_lane` 0..3, then `out_valid`=0.
- Back-to-back:
  - Stimulus: two words with `in_valid` held high.
  - Expected: 8 consecutive valid cycles. `in_ready` pulses only on the lane-3 handshake cycle.
- Backpressure:
  - Stimulus: `out_ready`=0 for 3 cycles during lane 1.
  - Expected: `out_data`=0xFF80 and `out_lane`=1 held; total duration 7 cycles.
- Unsigned config:
  - Config: unsigned in/out, same widths.
  - Stimulus: lane 0xF8.
  - Expected: output 0x0F80, no sign fill.
- Reset mid-word:
  - Stimulus: `reset`=1 after lane 1 emitted.
  - Expected: next cycle `out_valid`=0, `out_lane`=0. After release, IDLE with `in_ready`=1 and no stale lanes emitted.
- `EXP_FXP_LAST_EN` defined:
  - Expected: `out_last`=1 only alongside `out_lane`=3, including during a stall on lane 3.
